// File: rtl/temporizador_mmss.sv
// MM:SS BCD countdown timer with load/start/stop control and a 1 Hz tick enable.
// Digits, running and done are registered; zero is decoded from the digit registers.
module temporizador_mmss #(
  parameter int SEC_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        zero,
  output logic        done
);

  localparam logic [3:0] ST_MAX = 4'(SEC_TENS_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_reg;
  logic [3:0] sat_digit [4];
  logic       last_sec;

  // Nibble 1 is the seconds-tens digit; every other digit caps at 9.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sat
    localparam logic [3:0] LIM = (gi == 1) ? ST_MAX : 4'd9;
    assign sat_digit[gi] = (data[gi*4 +: 4] > LIM) ? LIM : data[gi*4 +: 4];
  end

  assign zero     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign last_sec = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      min_tens  <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        running <= 1'b0;
        if (state_reg == RUN) begin
          state_reg <= PAUSE;
        end else begin
          state_reg <= IDLE;
          sec_ones  <= 4'd0;
          sec_tens  <= 4'd0;
          min_ones  <= 4'd0;
          min_tens  <= 4'd0;
        end
      end else if (load && state_reg != RUN) begin
        state_reg <= IDLE;
        running   <= 1'b0;
        sec_ones  <= sat_digit[0];
        sec_tens  <= sat_digit[1];
        min_ones  <= sat_digit[2];
        min_tens  <= sat_digit[3];
      end else if (start && (state_reg == IDLE || state_reg == PAUSE) && !zero) begin
        state_reg <= RUN;
        running   <= 1'b1;
      end else if (tick && state_reg == RUN && !zero) begin
        // Reaching 00:00 leaves RUN on the same edge so zero never lingers in RUN.
        if (last_sec) begin
          state_reg <= DONE;
          running   <= 1'b0;
          done      <= 1'b1;
        end
        if (sec_ones != 4'd0) begin
          sec_ones <= sec_ones - 4'd1;
        end else begin
          sec_ones <= 4'd9;
          if (sec_tens != 4'd0) begin
            sec_tens <= sec_tens - 4'd1;
          end else begin
            sec_tens <= ST_MAX;
            if (min_ones != 4'd0) begin
              min_ones <= min_ones - 4'd1;
            end else begin
              min_ones <= 4'd9;
              min_tens <= min_tens - 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_temporizador_mmss.sv
// Bench for temporizador_mmss: directed vector table, hand-written corner sequences,
// then random stimulus against a seconds-count reference model.
module tb_temporizador_mmss;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic        load, start, stop, tick;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic        running, zero, done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  temporizador_mmss #(.SEC_TENS_MAX(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: the count is held as total seconds.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_total = 0;
  logic    m_done  = 1'b0;

  function automatic int sat(int d, int lim);
    return (d > lim) ? lim : d;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_total = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(logic [15:0] d, logic l, logic s, logic p, logic t);
    m_done = 1'b0;
    if (p) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
      else begin
        m_state = M_IDLE;
        m_total = 0;
      end
    end else if (l && m_state != M_RUN) begin
      m_total = sat(int'(d[15:12]), 9) * 600 + sat(int'(d[11:8]), 9) * 60 +
                sat(int'(d[7:4]), 5) * 10 + sat(int'(d[3:0]), 9);
      m_state = M_IDLE;
    end else if (s && (m_state == M_IDLE || m_state == M_PAUSE) && m_total != 0) begin
      m_state = M_RUN;
    end else if (t && m_state == M_RUN) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_state = M_DONE;
        m_done  = 1'b1;
      end
    end
  endtask

  function automatic logic [18:0] model_out();
    int mins, secs;
    mins = m_total / 60;
    secs = m_total % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            m_state == M_RUN, m_total == 0, m_done};
  endfunction

  function automatic logic [18:0] dut_out();
    return {min_tens, min_ones, sec_tens, sec_ones, running, zero, done};
  endfunction

  function automatic logic [18:0] expect_of(logic [15:0] digits, logic run, logic dn);
    return {digits, run, digits == 16'h0000, dn};
  endfunction

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h (mm:ss %h run/zero/done %b) expected %h (mm:ss %h run/zero/done %b)",
               name, act, act[18:3], act[2:0], exp, exp[18:3], exp[2:0]);
    end
  endtask

  // Drive one cycle of inputs, step the model on the edge, settle #1 afterwards.
  task automatic drive_cycle(logic [15:0] d, logic l, logic s, logic p, logic t);
    data  = d;
    load  = l;
    start = s;
    stop  = p;
    tick  = t;
    @(posedge clk);
    model_step(d, l, s, p, t);
    #1;
    cyc++;
    $display("cyc %0d data=%h l=%b s=%b p=%b t=%b -> %h%h:%h%h run=%b zero=%b done=%b",
             cyc, d, l, s, p, t, min_tens, min_ones, sec_tens, sec_ones, running, zero, done);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        load, start, stop, tick;
    logic [15:0] exp_digits;
    logic        exp_running, exp_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic [15:0] d, logic l, logic s, logic p, logic t,
                     logic [15:0] ed, logic er, logic edn);
    vec_t v;
    v.data = d; v.load = l; v.start = s; v.stop = p; v.tick = t;
    v.exp_digits = ed; v.exp_running = er; v.exp_done = edn;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    data  = 16'h0000;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;

    //   data     ld st sp tk   expected  run done
    add(16'h0103, 1, 0, 0, 0, 16'h0103, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h0103, 1, 0);
    add(16'h0000, 0, 0, 0, 1, 16'h0102, 1, 0);
    add(16'h0000, 0, 0, 0, 1, 16'h0101, 1, 0);
    add(16'h0000, 0, 0, 0, 1, 16'h0100, 1, 0);
    add(16'h0000, 0, 0, 1, 0, 16'h0100, 0, 0);
    add(16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0);
    add(16'h0002, 1, 0, 0, 0, 16'h0002, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h0002, 1, 0);
    add(16'h0000, 0, 0, 0, 1, 16'h0001, 1, 0);
    add(16'h0000, 0, 0, 0, 1, 16'h0000, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(16'h0000, 0, 1, 0, 1, 16'h0000, 0, 0);
    add(16'h1000, 1, 0, 0, 0, 16'h1000, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h1000, 1, 0);
    add(16'h0000, 0, 0, 0, 1, 16'h0959, 1, 0);
    add(16'h0000, 0, 0, 1, 0, 16'h0959, 0, 0);
    add(16'hFF7A, 1, 0, 0, 0, 16'h9959, 0, 0);
    add(16'h0030, 1, 0, 0, 0, 16'h0030, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h0030, 1, 0);
    add(16'h0000, 0, 0, 1, 1, 16'h0030, 0, 0);
    add(16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0);
    add(16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0);
    add(16'h0100, 1, 0, 0, 0, 16'h0100, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h0100, 1, 0);
    add(16'h0555, 1, 0, 0, 1, 16'h0059, 1, 0);
    add(16'h0555, 1, 0, 1, 0, 16'h0059, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 16'h0059, 1, 0);
    add(16'h0000, 0, 1, 0, 1, 16'h0058, 1, 0);

    // Reset state, sampled before any clock edge.
    #2;
    check("reset_outputs", dut_out(), expect_of(16'h0000, 1'b0, 1'b0));
    check("reset_state", {17'b0, 2'(dut.state_reg)}, 19'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].data, tbl[i].load, tbl[i].start, tbl[i].stop, tbl[i].tick);
      check($sformatf("table_row_%0d", i), dut_out(),
            expect_of(tbl[i].exp_digits, tbl[i].exp_running, tbl[i].exp_done));
    end

    // Final tick lands in DONE; done lasts one cycle while the state stays DONE.
    drive_cycle(16'h0001, 1, 0, 1, 0);
    drive_cycle(16'h0001, 1, 0, 0, 0);
    drive_cycle(16'h0000, 0, 1, 0, 0);
    drive_cycle(16'h0000, 0, 0, 0, 1);
    check("done_edge", dut_out(), expect_of(16'h0000, 1'b0, 1'b1));
    check("done_state", {17'b0, 2'(dut.state_reg)}, 19'd3);
    drive_cycle(16'h0000, 0, 0, 0, 1);
    check("done_one_cycle", dut_out(), expect_of(16'h0000, 1'b0, 1'b0));
    check("done_state_held", {17'b0, 2'(dut.state_reg)}, 19'd3);

    // Held tick decrements every cycle across a minute borrow.
    drive_cycle(16'h0201, 1, 0, 0, 0);
    drive_cycle(16'h0000, 0, 1, 0, 0);
    drive_cycle(16'h0000, 0, 0, 0, 1);
    drive_cycle(16'h0000, 0, 0, 0, 1);
    check("held_tick", dut_out(), expect_of(16'h0159, 1'b1, 1'b0));

    // Asynchronous reset mid-RUN at 05:17, observed before the next edge.
    drive_cycle(16'h0517, 1, 0, 1, 0);
    drive_cycle(16'h0517, 1, 0, 0, 0);
    drive_cycle(16'h0000, 0, 1, 0, 0);
    check("run_at_0517", dut_out(), expect_of(16'h0517, 1'b1, 1'b0));
    #4;
    reset = 1'b0;
    model_reset();
    #2;
    check("async_reset_outputs", dut_out(), expect_of(16'h0000, 1'b0, 1'b0));
    check("async_reset_state", {17'b0, 2'(dut.state_reg)}, 19'd0);
    #1;
    reset = 1'b1;
    drive_cycle(16'h0042, 1, 0, 0, 0);
    check("first_edge_after_reset", dut_out(), expect_of(16'h0042, 1'b0, 1'b0));

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] d;
      logic l, s, p, t;
      case ($urandom_range(0, 3))
        0:       d = 16'($urandom);
        1:       d = {4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        default: d = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      endcase
      p = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 1) == 0);
      drive_cycle(d, l, s, p, t);
      check($sformatf("random_%0d", n), dut_out(), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temporizador_mmss.md
TEMPORIZADOR_MMSS -- requirements
Module: temporizador_mmss

Interface
REQ-001 The parameter SEC_TENS_MAX SHALL have default 5 and SHALL set the maximum seconds-tens digit and its borrow reload value.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state changes on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-low reset.
REQ-004 The port data SHALL be an input, 16 bits wide, carrying BCD {min_tens, min_ones, sec_tens, sec_ones}.
REQ-005 The port load SHALL be an input, 1 bit wide, requesting capture of data into the count.
REQ-006 The port start SHALL be an input, 1 bit wide, requesting that countdown begin or resume.
REQ-007 The port stop SHALL be an input, 1 bit wide, requesting pause or cancel.
REQ-008 The port tick SHALL be an input, 1 bit wide, a one-cycle 1 Hz enable pulse.
REQ-009 The ports sec_ones, sec_tens, min_ones and min_tens SHALL be outputs, 4 bits wide each, carrying the registered BCD digits.
REQ-010 The port running SHALL be an output, 1 bit wide, high exactly while the state is RUN.
REQ-011 The port zero SHALL be an output, 1 bit wide, high when all four digits are 0, decoded from the registers.
REQ-012 The port done SHALL be an output, 1 bit wide, a registered single-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN, PAUSE and DONE.
REQ-014 Inputs SHALL be evaluated per cycle with priority stop > load > start > tick; only the highest-priority applicable input SHALL act.
REQ-015 A stop in RUN SHALL go to PAUSE with digits held.
REQ-016 A stop in PAUSE or DONE SHALL go to IDLE with all digits cleared to 0.
REQ-017 A stop in IDLE SHALL clear the digits and remain in IDLE.
REQ-018 A load in IDLE, PAUSE or DONE SHALL capture data into the digits and go to IDLE.
REQ-019 A load in RUN SHALL be ignored.
REQ-020 On load, any ones digit greater than 9 SHALL saturate to 9, min_tens greater than 9 SHALL saturate to 9, and sec_tens greater than SEC_TENS_MAX SHALL saturate to SEC_TENS_MAX.
REQ-021 A start in IDLE or PAUSE with zero low SHALL go to RUN.
REQ-022 A start with zero high, or in DONE or RUN, SHALL be ignored.
REQ-023 A tick in RUN SHALL decrement the count by one second on that edge, with latency 1 cycle from tick sampled to new digits visible.
REQ-024 The decrement borrow chain SHALL be: sec_ones 0 to 9 borrows from sec_tens; sec_tens 0 to SEC_TENS_MAX borrows from min_ones; min_ones 0 to 9 borrows from min_tens.
REQ-025 The count SHALL never wrap below 00:00 (for example, 10:00 goes to 09:59).
REQ-026 A tick that takes the count from 00:01 to 00:00 SHALL move the FSM to DONE and pulse done high on the same edge for exactly one cycle.
REQ-027 A tick outside RUN SHALL be ignored.
REQ-028 A tick coincident with stop in RUN SHALL cause no decrement and SHALL go to PAUSE.
REQ-029 In RUN, zero SHALL never be high for more than the single DONE-transition edge; the FSM SHALL leave RUN on reaching 00:00.
REQ-030 A tick held high for multiple cycles SHALL decrement once per cycle, with no internal edge detection.

Reset
REQ-031 When reset is low, all digits SHALL be 0, the state SHALL be IDLE, running and done SHALL be 0, and zero SHALL be 1, immediately and independent of clk.
REQ-032 A reset assertion during RUN SHALL abort the countdown with no done pulse.
REQ-033 After reset deasserts, the first active edge SHALL process inputs normally.

Verification
REQ-034 The bench SHALL load data=16'h0103, start, apply 3 ticks, and check the digits step 01:02, 01:01, 01:00, with running=1 throughout.
REQ-035 The bench SHALL load 16'h0002, start, apply 2 ticks, and check 00:01, then 00:00 with done=1 for one cycle, the state DONE, running=0 and zero=1.
REQ-036 The bench SHALL load 16'h1000, start, apply 1 tick, and check 09:59.
REQ-037 The bench SHALL apply a single cycle with load of 16'hFF7A, and check the digits saturate to 99:59.
REQ-038 The bench SHALL, in RUN at 00:30, assert tick together with stop, check PAUSE at 00:30, then stop again and check IDLE at 00:00.
REQ-039 The bench SHALL pull reset low mid-RUN at 05:17, and check the digits are 0, state IDLE and done=0 before the next clk edge.
